dsp_cfg_rx: RTL and testbench
=============================

// Module: dsp_cfg_rx
// PURPOSE
//  Command decoder that writes the run-time configuration consumed by the DSP chain.
//  - Configuration: N_r, M_r, N_l, M_l and the 8 bypass switches.
//  - Input: byte stream from the UART receiver.
//  - Frames: validated, range-checked and acknowledged; the ACK/NAK byte goes to the UART transmitter.
//  - Accepted values are staged in shadow registers and committed to the outputs only on a
//    data_en strobe, so the filter/downsample/requantize/interpol chain never sees a change
//    mid-sample.
// PARAMETERS
//  N_DEFAULT      5'd4     reset value of N_r/N_l (rate factor)
//  M_DEFAULT      5'd0     reset value of M_r/M_l (bits removed)
//  SW_DEFAULT     8'h00    reset value of switches (all modules active)
//  N_MAX          5'd16    largest legal N; legal N range is 1..N_MAX
//  M_MAX          5'd17    largest legal M; legal M range is 0..M_MAX
//  TIMEOUT_CYCLES 24'd5000000  inter-byte timeout in clock cycles (>=2)
// PORTS
//  clock         in   1  master clock
//  reset         in   1  asynchronous, active-low reset
//  rx_data       in   8  byte from UART receiver
//  rx_valid      in   1  1-cycle strobe, rx_data valid
//  tx_data       out  8  response byte to UART transmitter
//  tx_valid      out  1  response valid; held until tx_ready
//  tx_ready      in   1  transmitter accepts tx_data when tx_valid&tx_ready
//  data_en       in   1  48 kHz sample strobe (commit point)
//  N_r,M_r,N_l,M_l out 5 committed configuration
//  switches      out  8  committed bypass switches
//  cfg_update    out  1  1-cycle pulse on the cycle the outputs change
//  frame_err     out  1  1-cycle pulse: bad checksum/cmd/range, timeout, or overrun
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE.
//   - Shadow and committed regs = defaults.
//   - tx_valid=0, tx_data=0, cfg_update=0, frame_err=0, pending=0, timeout counter=0.
//  Frame format: 0xA5, CMD, VAL, CHK, where CHK = CMD^VAL.
//   - CMD 0x01 N_r, 0x02 M_r, 0x03 N_l, 0x04 M_l, 0x05 switches, 0x06 N both, 0x07 M both.
//  FSM (advances only on rx_valid):
//   - IDLE: 0xA5 -> CMD; any other byte is ignored (no error).
//   - CMD: latch byte -> VAL.
//   - VAL: latch byte -> CHK.
//   - CHK: evaluate -> RESP.
//      - Valid frame: write shadow, set pending, tx_data=0x06 (ACK).
//      - Invalid frame: shadow untouched, tx_data=0x15 (NAK), frame_err pulse.
//      - Invalid = CHK mismatch, unknown CMD, N outside 1..N_MAX, or M>M_MAX.
//      - For N/M commands VAL[7:5] must be 0, else NAK.
//   - RESP: tx_valid=1; on tx_valid&tx_ready -> IDLE, tx_valid=0 the next cycle.
//  Latency: ACK/NAK tx_valid asserts the cycle after the CHK byte's rx_valid.
//  Overrun: rx_valid while in RESP -> byte dropped, frame_err pulse, response still sent.
//  Timeout: counter clears on every rx_valid and counts in CMD/VAL/CHK.
//   - At TIMEOUT_CYCLES-1: -> IDLE, frame_err pulse, no response.
//   - IDLE and RESP never time out.
//  Commit: on data_en with pending=1, committed<=shadow, pending<=0, cfg_update pulse (same edge).
//   - A frame accepted on the same cycle as data_en commits at the NEXT data_en.
//   - Several frames between strobes: last shadow values win, single cfg_update.
//  data_en with pending=0: no change, no pulse.
//  Reset mid-frame or mid-RESP: partial frame discarded; uncommitted shadow lost.
// CONFIGURATION
//  DSP_CFG_READBACK_EN defined:
//   - CMD 0x81..0x85 reads the committed register of CMD 0x01..0x05. VAL is ignored;
//     CHK must still equal CMD^VAL.
//   - Response is the register value, zero-extended to 8 bits, instead of ACK; no shadow write.
//   - Bad CHK -> NAK.
//  Not defined: CMD 0x81..0x85 are unknown commands -> NAK + frame_err.
// TESTING
//  1 reset low 3 cycles -> N_r=N_l=4, M_r=M_l=0, switches=0x00, tx_valid=0.
//  2 A5 01 08 09 -> tx 0x06; N_r stays 4 until next data_en, then N_r=8 with cfg_update 1 cycle.
//  3 A5 02 12 10 (M=18) -> tx 0x15, frame_err, M_r unchanged; A5 01 00 01 (N=0) -> 0x15.
//  4 A5 05 F0 00 (bad CHK, expected F5) -> 0x15; then A5 05 F0 F5 -> 0x06, switches=0xF0 after data_en.
//  5 A5 03 then silence TIMEOUT_CYCLES -> frame_err, no tx; next A5 04 03 07 -> 0x06, M_l=3.
//  6 tx_ready held 0 while an extra byte arrives in RESP -> frame_err, tx_valid held;
//    with DSP_CFG_READBACK_EN, A5 81 00 81 -> tx 0x08 (current N_r).

Source files
------------

// File: rtl/dsp_cfg_rx_if.sv
// Byte-stream link between the UART and the configuration decoder.
// The master drives received bytes and tx_ready; the slave (decoder) returns the response.
interface dsp_cfg_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/dsp_cfg_rx.sv
// Frame decoder for the DSP-chain configuration; values are shadowed and committed on data_en_i.
// Define DSP_CFG_READBACK_EN to enable CMD 0x81..0x85 readback of the committed registers.
//
// state  | meaning
// S_IDLE | waiting for 0xA5 sync byte
// S_CMD  | waiting for command byte
// S_VAL  | waiting for value byte
// S_CHK  | waiting for checksum byte, frame evaluated on arrival
// S_RESP | holding ACK/NAK/readback byte until tx_ready
module dsp_cfg_rx #(
  parameter logic [4:0]  N_DEFAULT      = 5'd4,
  parameter logic [4:0]  M_DEFAULT      = 5'd0,
  parameter logic [7:0]  SW_DEFAULT     = 8'h00,
  parameter logic [4:0]  N_MAX          = 5'd16,
  parameter logic [4:0]  M_MAX          = 5'd17,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  dsp_cfg_rx_if.slave   bus,
  input  logic          data_en_i,
  output logic [4:0]    n_r_o,
  output logic [4:0]    m_r_o,
  output logic [4:0]    n_l_o,
  output logic [4:0]    m_l_o,
  output logic [7:0]    switches_o,
  output logic          cfg_update_o,
  output logic          frame_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_VAL, S_CHK, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, val_q, tx_data_q;
  logic [23:0] tmr_q;
  logic        frame_err_q, cfg_update_q, pending_q;
  logic [4:0]  sh_n_r_q, sh_m_r_q, sh_n_l_q, sh_m_l_q;
  logic [7:0]  sh_sw_q;
  logic [4:0]  n_r_q, m_r_q, n_l_q, m_l_q;
  logic [7:0]  sw_q;

  logic        in_frame, timeout_hit, chk_done, frame_ok, accept, rd_hit;
  logic        n_ok, m_ok, cmd_ok;
  logic [7:0]  rd_val;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.rx_valid && bus.rx_data == 8'hA5) state_d = S_CMD;
      S_CMD:  if (bus.rx_valid) state_d = S_VAL; else if (timeout_hit) state_d = S_IDLE;
      S_VAL:  if (bus.rx_valid) state_d = S_CHK; else if (timeout_hit) state_d = S_IDLE;
      S_CHK:  if (bus.rx_valid) state_d = S_RESP; else if (timeout_hit) state_d = S_IDLE;
      S_RESP: if (bus.tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid = (state_q == S_RESP);
    in_frame     = (state_q == S_CMD) || (state_q == S_VAL) || (state_q == S_CHK);
    timeout_hit  = in_frame && !bus.rx_valid && (tmr_q == 24'd0);
    chk_done     = (state_q == S_CHK) && bus.rx_valid;
    n_ok   = (val_q[7:5] == 3'b000) && (val_q[4:0] != 5'd0) && (val_q[4:0] <= N_MAX);
    m_ok   = (val_q[7:5] == 3'b000) && (val_q[4:0] <= M_MAX);
    cmd_ok = 1'b0;
    rd_hit = 1'b0;
    rd_val = 8'h00;
    case (cmd_q)
      8'h01, 8'h03, 8'h06: cmd_ok = n_ok;
      8'h02, 8'h04, 8'h07: cmd_ok = m_ok;
      8'h05:               cmd_ok = 1'b1;
`ifdef DSP_CFG_READBACK_EN
      8'h81: begin cmd_ok = 1'b1; rd_hit = 1'b1; rd_val = {3'b000, n_r_q}; end
      8'h82: begin cmd_ok = 1'b1; rd_hit = 1'b1; rd_val = {3'b000, m_r_q}; end
      8'h83: begin cmd_ok = 1'b1; rd_hit = 1'b1; rd_val = {3'b000, n_l_q}; end
      8'h84: begin cmd_ok = 1'b1; rd_hit = 1'b1; rd_val = {3'b000, m_l_q}; end
      8'h85: begin cmd_ok = 1'b1; rd_hit = 1'b1; rd_val = sw_q; end
`endif
      default: cmd_ok = 1'b0;
    endcase
    frame_ok = (bus.rx_data == (cmd_q ^ val_q)) && cmd_ok;
    accept   = chk_done && frame_ok && !rd_hit;
  end

  // Accept has priority over commit on pending so a same-edge frame waits for the next strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q <= 8'h00; val_q <= 8'h00; tx_data_q <= 8'h00; tmr_q <= 24'd0;
      frame_err_q <= 1'b0; cfg_update_q <= 1'b0; pending_q <= 1'b0;
      sh_n_r_q <= N_DEFAULT; sh_m_r_q <= M_DEFAULT; sh_n_l_q <= N_DEFAULT;
      sh_m_l_q <= M_DEFAULT; sh_sw_q <= SW_DEFAULT;
      n_r_q <= N_DEFAULT; m_r_q <= M_DEFAULT; n_l_q <= N_DEFAULT;
      m_l_q <= M_DEFAULT; sw_q <= SW_DEFAULT;
    end else begin
      if (bus.rx_valid)                   tmr_q <= TIMEOUT_CYCLES - 24'd1;
      else if (in_frame && tmr_q != 24'd0) tmr_q <= tmr_q - 24'd1;

      if (state_q == S_CMD && bus.rx_valid) cmd_q <= bus.rx_data;
      if (state_q == S_VAL && bus.rx_valid) val_q <= bus.rx_data;
      if (chk_done) tx_data_q <= frame_ok ? (rd_hit ? rd_val : 8'h06) : 8'h15;

      frame_err_q <= (chk_done && !frame_ok) || timeout_hit ||
                     ((state_q == S_RESP) && bus.rx_valid);

      cfg_update_q <= data_en_i && pending_q;
      if (data_en_i && pending_q) begin
        n_r_q <= sh_n_r_q; m_r_q <= sh_m_r_q; n_l_q <= sh_n_l_q;
        m_l_q <= sh_m_l_q; sw_q <= sh_sw_q;
        pending_q <= 1'b0;
      end

      if (accept) begin
        pending_q <= 1'b1;
        case (cmd_q)
          8'h01: sh_n_r_q <= val_q[4:0];
          8'h02: sh_m_r_q <= val_q[4:0];
          8'h03: sh_n_l_q <= val_q[4:0];
          8'h04: sh_m_l_q <= val_q[4:0];
          8'h05: sh_sw_q  <= val_q;
          8'h06: begin sh_n_r_q <= val_q[4:0]; sh_n_l_q <= val_q[4:0]; end
          8'h07: begin sh_m_r_q <= val_q[4:0]; sh_m_l_q <= val_q[4:0]; end
          default: ;
        endcase
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign n_r_o        = n_r_q;
  assign m_r_o        = m_r_q;
  assign n_l_o        = n_l_q;
  assign m_l_o        = m_l_q;
  assign switches_o   = sw_q;
  assign cfg_update_o = cfg_update_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_dsp_cfg_rx.sv
// Directed bench for dsp_cfg_rx with a shortened inter-byte timeout.
module tb_dsp_cfg_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_en;
  logic [4:0] n_r, m_r, n_l, m_l;
  logic [7:0] sw;
  logic       cfg_update, frame_err;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       saw_err, saw_tx;

  dsp_cfg_rx_if bus ();

  dsp_cfg_rx #(.TIMEOUT_CYCLES(24'd20)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .data_en_i(data_en),
    .n_r_o(n_r), .m_r_o(m_r), .n_l_o(n_l), .m_l_o(m_l), .switches_o(sw),
    .cfg_update_o(cfg_update), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic en);
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1; data_en = en;
    @(negedge clk);
    bus.rx_valid = 1'b0; data_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] v, input logic [7:0] k);
    send_byte(8'hA5, 1'b0); send_byte(c, 1'b0); send_byte(v, 1'b0); send_byte(k, 1'b0);
  endtask

  task automatic ack_resp();
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check("tx_valid_drop", {31'd0, bus.tx_valid}, 32'd0);
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp_data, input logic exp_err);
    check({tag, "_txv"}, {31'd0, bus.tx_valid}, 32'd1);
    check({tag, "_txd"}, {24'd0, bus.tx_data}, {24'd0, exp_data});
    check({tag, "_err"}, {31'd0, frame_err}, {31'd0, exp_err});
    ack_resp();
  endtask

  task automatic strobe(input logic exp_upd);
    @(negedge clk); data_en = 1'b1;
    @(negedge clk); data_en = 1'b0;
    check("cfg_update", {31'd0, cfg_update}, {31'd0, exp_upd});
  endtask

  initial begin
    rst_n = 1'b0; data_en = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_n_r", {27'd0, n_r}, 32'd4);
    check("rst_n_l", {27'd0, n_l}, 32'd4);
    check("rst_m_r", {27'd0, m_r}, 32'd0);
    check("rst_m_l", {27'd0, m_l}, 32'd0);
    check("rst_sw", {24'd0, sw}, 32'h00);
    check("rst_txv", {31'd0, bus.tx_valid}, 32'd0);
    rst_n = 1'b1;

    // N_r=8 staged, visible only after data_en
    send_frame(8'h01, 8'h08, 8'h09);
    expect_resp("nr8", 8'h06, 1'b0);
    check("nr_staged", {27'd0, n_r}, 32'd4);
    strobe(1'b1);
    check("nr_commit", {27'd0, n_r}, 32'd8);
    @(negedge clk);
    check("upd_pulse_len", {31'd0, cfg_update}, 32'd0);
    strobe(1'b0);

    // range boundaries and malformed frames
    send_frame(8'h02, 8'h12, 8'h10); expect_resp("m18", 8'h15, 1'b1);
    send_frame(8'h01, 8'h00, 8'h01); expect_resp("n0", 8'h15, 1'b1);
    send_frame(8'h01, 8'h11, 8'h10); expect_resp("n17", 8'h15, 1'b1);
    send_frame(8'h01, 8'h21, 8'h20); expect_resp("n_hibits", 8'h15, 1'b1);
    send_frame(8'h09, 8'h00, 8'h09); expect_resp("badcmd", 8'h15, 1'b1);
    send_frame(8'h02, 8'h11, 8'h13); expect_resp("m17", 8'h06, 1'b0);
    send_frame(8'h01, 8'h10, 8'h11); expect_resp("n16", 8'h06, 1'b0);
    send_frame(8'h05, 8'hF0, 8'h00); expect_resp("sw_badchk", 8'h15, 1'b1);
    check("m_r_hold", {27'd0, m_r}, 32'd0);
    send_frame(8'h05, 8'hF0, 8'hF5); expect_resp("sw_f0", 8'h06, 1'b0);
    strobe(1'b1);
    check("m_r_17", {27'd0, m_r}, 32'd17);
    check("n_r_16", {27'd0, n_r}, 32'd16);
    check("sw_f0_commit", {24'd0, sw}, 32'hF0);

    // inter-byte timeout
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0);
    saw_err = 1'b0; saw_tx = 1'b0;
    for (int i = 0; i < 100 && !saw_err; i++) begin
      @(negedge clk);
      if (frame_err) saw_err = 1'b1;
      if (bus.tx_valid) saw_tx = 1'b1;
    end
    check("timeout_err", {31'd0, saw_err}, 32'd1);
    check("timeout_notx", {31'd0, saw_tx}, 32'd0);
    send_frame(8'h04, 8'h03, 8'h07); expect_resp("ml3", 8'h06, 1'b0);
    strobe(1'b1);
    check("m_l_3", {27'd0, m_l}, 32'd3);

    // accept coincident with data_en commits the older shadow only
    send_frame(8'h03, 8'h02, 8'h01); expect_resp("nl2", 8'h06, 1'b0);
    send_byte(8'hA5, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b1);
    check("same_upd", {31'd0, cfg_update}, 32'd1);
    check("same_n_l", {27'd0, n_l}, 32'd2);
    check("same_n_r", {27'd0, n_r}, 32'd16);
    expect_resp("nboth5", 8'h06, 1'b0);
    strobe(1'b1);
    check("both_n_r", {27'd0, n_r}, 32'd5);
    check("both_n_l", {27'd0, n_l}, 32'd5);

    // overrun while response is held
    send_frame(8'h01, 8'h08, 8'h09);
    @(negedge clk);
    send_byte(8'h55, 1'b0);
    check("ovr_err", {31'd0, frame_err}, 32'd1);
    check("ovr_txv", {31'd0, bus.tx_valid}, 32'd1);
    check("ovr_txd", {24'd0, bus.tx_data}, 32'h06);
    ack_resp();
    strobe(1'b1);
    check("ovr_n_r", {27'd0, n_r}, 32'd8);

`ifdef DSP_CFG_READBACK_EN
    send_frame(8'h81, 8'h00, 8'h81); expect_resp("rd_nr", 8'h08, 1'b0);
    send_frame(8'h85, 8'h00, 8'h85); expect_resp("rd_sw", 8'hF0, 1'b0);
    send_frame(8'h84, 8'h00, 8'h00); expect_resp("rd_badchk", 8'h15, 1'b1);
`else
    send_frame(8'h81, 8'h00, 8'h81); expect_resp("rd_unknown", 8'h15, 1'b1);
`endif

    // reset discards uncommitted shadow
    send_frame(8'h01, 8'h03, 8'h02); expect_resp("nr3", 8'h06, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("rst2_n_r", {27'd0, n_r}, 32'd4);
    check("rst2_sw", {24'd0, sw}, 32'h00);
    rst_n = 1'b1;
    strobe(1'b0);
    check("rst2_n_r_after", {27'd0, n_r}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
